// File: rtl/mips_mc_sequencer_if.sv
// -----------------------------------------------------------------------------
// mips_mc_sequencer_if
// Bundle between the multicycle MIPS datapath/memory side and the main
// sequencer.
//   run       : FETCH advances only while high
//   opcode    : IR[31:26], valid from DECODE onward
//   funct     : IR[5:0], valid from DECODE onward
//   mem_ready : memory finished the current read/write this cycle
//   state     : current sequencer state (feeds the control decoder)
//   halted    : high while in HALT
//   error     : high while in ERROR
//   retired   : count of completed instructions
// Modports: master drives run/opcode/funct/mem_ready and observes status.
// slave is the sequencer side.
// -----------------------------------------------------------------------------
interface mips_mc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic [3:0]       state;
  logic             halted;
  logic             error;
  logic [CNT_W-1:0] retired;

  modport master (
    output run, opcode, funct, mem_ready,
    input  state, halted, error, retired
  );

  modport slave (
    input  run, opcode, funct, mem_ready,
    output state, halted, error, retired
  );
endinterface

// File: rtl/mips_mc_sequencer.sv
// -----------------------------------------------------------------------------
// mips_mc_sequencer
// Main state machine of the multicycle MIPS core. It walks fetch, decode,
// execute, memory and writeback steps from the latched opcode. In the memory
// wait states it waits on mem_ready, with a timeout that leads to ERROR. It
// also counts retired instructions.
// Ports:
//   i_clk : system clock, rising edge
//   i_rst : synchronous, active-high reset
//   bus   : mips_mc_sequencer_if.slave (run, opcode, funct, mem_ready in;
//           state, halted, error, retired out)
// State encodings are shared with the control decoder:
//   0 FETCH, 1 READ_FROM_MEMORY, 2 DECODE, 3 EXECUTE, 4 ALU_WRITEBACK,
//   5 MEM_ADDR, 6 MEM_READ, 7 MEM_WRITEBACK, 8 MEM_WRITE, 9 BRANCH,
//   10 JUMP, 11 ITYPE_EXECUTE, 12 ITYPE_WRITEBACK, 13 HALT, 14 ERROR.
//   Value 15 is unused.
// -----------------------------------------------------------------------------
module mips_mc_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mips_mc_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH            = 4'd0,
    S_READ_FROM_MEMORY = 4'd1,
    S_DECODE           = 4'd2,
    S_EXECUTE          = 4'd3,
    S_ALU_WRITEBACK    = 4'd4,
    S_MEM_ADDR         = 4'd5,
    S_MEM_READ         = 4'd6,
    S_MEM_WRITEBACK    = 4'd7,
    S_MEM_WRITE        = 4'd8,
    S_BRANCH           = 4'd9,
    S_JUMP             = 4'd10,
    S_ITYPE_EXECUTE    = 4'd11,
    S_ITYPE_WRITEBACK  = 4'd12,
    S_HALT             = 4'd13,
    S_ERROR            = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // The wait counter only ever has to reach MEM_TIMEOUT-1.
  localparam int         WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e             r_state;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_halted;
  logic               r_error;
  logic [CNT_W-1:0]   r_retired;

  state_e             w_next;
  logic               w_retire;
  logic               w_is_wait;
  logic               w_timeout;

  assign w_is_wait = (r_state == S_READ_FROM_MEMORY) ||
                     (r_state == S_MEM_READ) ||
                     (r_state == S_MEM_WRITE);

  // When mem_ready arrives on the last allowed cycle, it wins over the timeout.
  assign w_timeout = (r_wait == WAIT_LAST) && !bus.mem_ready;

  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:            if (bus.run) w_next = S_READ_FROM_MEMORY;
      S_READ_FROM_MEMORY: begin
        if (bus.mem_ready)  w_next = S_DECODE;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_DECODE: begin
        casez (bus.opcode)
          OP_RTYPE:       w_next = S_EXECUTE;
          OP_LW, OP_SW:   w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:           w_next = S_JUMP;
          6'b001???:      w_next = S_ITYPE_EXECUTE;
          OP_HALT:        w_next = S_HALT;
          default:        w_next = S_ERROR;
        endcase
      end
      S_EXECUTE:          w_next = S_ALU_WRITEBACK;
      // Load versus store is decided here from the opcode held in this cycle.
      S_MEM_ADDR:         w_next = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (bus.mem_ready)  w_next = S_MEM_WRITEBACK;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (w_timeout) begin
          w_next = S_ERROR;
        end
      end
      S_ALU_WRITEBACK, S_MEM_WRITEBACK, S_BRANCH, S_JUMP, S_ITYPE_WRITEBACK: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_ITYPE_EXECUTE:    w_next = S_ITYPE_WRITEBACK;
      S_HALT:             w_next = S_HALT;
      S_ERROR:            w_next = S_ERROR;
      default:            w_next = S_ERROR;  // unused encoding 15
    endcase
  end

  // NOTE: all state lives in this clocked block and uses non-blocking
  // assignments, so every register samples the pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_halted  <= 1'b0;
      r_error   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state  <= w_next;
      // The counter restarts on every entry into a wait state and counts
      // only while the machine stays there.
      if (w_is_wait && (w_next == r_state)) r_wait <= r_wait + 1'b1;
      else                                  r_wait <= '0;
      // Decode from the next state so the flags line up with the state output.
      r_halted <= (w_next == S_HALT);
      r_error  <= (w_next == S_ERROR);
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  assign bus.state   = r_state;
  assign bus.halted  = r_halted;
  assign bus.error   = r_error;
  assign bus.retired = r_retired;

endmodule
